aes8_round_ctrl: RTL and testbench



---
 rtl/aes8_round_ctrl_pkg.sv | 14 +
 rtl/aes8_round_ctrl_if.sv | 19 +
 rtl/aes8_round_ctrl_rcon.sv | 14 +
 rtl/aes8_round_ctrl.sv | 66 ++++++
 tb/tb_aes8_round_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/aes8_round_ctrl_pkg.sv
// aes8_pkg: shared opcode/state types and byte-index helpers for the AES-128 byte sequencer
package aes8_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_LOAD, OP_ARK, OP_KEYX, OP_SUB, OP_MIX, OP_OUT} op_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARK, S_KEYX, S_SUB, S_MIX, S_OUT} state_e;
  localparam logic [7:0] RCON_INIT = 8'h01;
  function automatic logic [3:0] sr_idx(input logic [3:0] c);
    logic [1:0] r;
    r = c[3:2] + c[1:0];
    return {r, c[1:0]};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
endpackage

// File: rtl/aes8_round_ctrl_if.sv
// aes8_round_ctrl_if: handshakes and datapath controls between front end, sequencer and byte path
interface aes8_round_ctrl_if;
  import aes8_pkg::*;
  logic start, in_valid, out_ready, in_ready, out_valid;
  op_e op;
  logic [3:0] st_raddr, st_waddr, key_idx, round;
  logic st_we, st_bank, last_round, busy, done;
  logic [7:0] rcon;
  modport slave (
    input start, in_valid, out_ready,
    output in_ready, out_valid, op, st_raddr, st_waddr, st_we, st_bank, key_idx, rcon, round,
      last_round, busy, done
  );
  modport master (
    output start, in_valid, out_ready,
    input in_ready, out_valid, op, st_raddr, st_waddr, st_we, st_bank, key_idx, rcon, round,
      last_round, busy, done
  );
endinterface

// File: rtl/aes8_round_ctrl_rcon.sv
// aes8_rcon_gen: AES round-constant register, reloaded per block and stepped by xtime
module aes8_rcon_gen
  import aes8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       adv,
  output logic [7:0] rcon
);
  always_ff @(posedge clk)
    if (rst || init) rcon <= RCON_INIT;
    else if (adv) rcon <= xtime(rcon);
endmodule

// File: rtl/aes8_round_ctrl.sv
// aes8_round_ctrl: sequences LOAD, ARK, NR x (KEYX, SUB, [MIX], ARK) and OUT over the byte-serial AES path
module aes8_round_ctrl
  import aes8_pkg::*;
#(
  parameter int NR = 10
) (
  input logic clk,
  input logic rst,
  aes8_round_ctrl_if.slave bus
);
  localparam logic [3:0] NR4 = 4'(NR);
  state_e state, state_nxt;
  logic [3:0] cnt, round;
  logic bank, done_r, step, fin, start_ok, toggle;
  always_comb begin
    start_ok = state == S_IDLE && bus.start;
    step = state == S_LOAD ? bus.in_valid : state == S_OUT ? bus.out_ready : state != S_IDLE;
    fin = step && cnt == 4'hF;
    toggle = fin && state inside {S_LOAD, S_ARK, S_SUB, S_MIX};
    state_nxt = state;
    if (start_ok) state_nxt = S_LOAD;
    else if (fin)
      case (state)
        S_LOAD:  state_nxt = S_ARK;
        S_ARK:   state_nxt = round == NR4 ? S_OUT : S_KEYX;
        S_KEYX:  state_nxt = S_SUB;
        S_SUB:   state_nxt = round < NR4 ? S_MIX : S_ARK;
        S_MIX:   state_nxt = S_ARK;
        default: state_nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      round  <= '0;
      bank   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= state_nxt != state ? 4'd0 : cnt + 4'(step);
      round  <= start_ok ? 4'd0 : fin && state == S_ARK && round != NR4 ? round + 4'd1 : round;
      bank   <= start_ok ? 1'b0 : bank ^ toggle;
      done_r <= fin && state == S_OUT;
    end
  aes8_rcon_gen u_rcon (
    .clk  (clk),
    .rst  (rst),
    .init (start_ok),
    .adv  (fin && state == S_KEYX),
    .rcon (bus.rcon)
  );
  // state and op encodings are kept in the same order, so op is a direct cast
  assign bus.op         = op_e'(state);
  assign bus.in_ready   = state == S_LOAD;
  assign bus.out_valid  = state == S_OUT;
  assign bus.busy       = state != S_IDLE;
  assign bus.done       = done_r;
  assign bus.st_we      = state == S_LOAD ? bus.in_valid : state inside {S_ARK, S_SUB, S_MIX};
  assign bus.st_waddr   = cnt;
  assign bus.st_raddr   = state == S_SUB ? sr_idx(cnt) : cnt;
  assign bus.key_idx    = state inside {S_ARK, S_KEYX} ? cnt : 4'd0;
  assign bus.st_bank    = bank;
  assign bus.round      = round;
  assign bus.last_round = round == NR4;
endmodule

// File: tb/tb_aes8_round_ctrl.sv
// tb_aes8_round_ctrl: directed full-block runs with stalls, ignored start and mid-round reset
module tb_aes8_round_ctrl;
  import aes8_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_pass = 0;
  op_e seq[$], exp_seq[$];
  logic [7:0] rc[$];
  logic [3:0] outs[$];
  int load_cycles, load_writes, out_cycles, done_cnt, lat;
  bit bank_ok, finished;
  const logic [7:0] exp_rc[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes8_round_ctrl_if bus();
  aes8_round_ctrl #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sub_exp(input int k);
    case (k)
      0: return 0;
      1: return 5;
      5: return 9;
      7: return 3;
      15: return 11;
      default: return -1;
    endcase
  endfunction

  task automatic run_block(input bit alt_in, input bit stall_out, input bit start_mid, input bit rst_mid);
    int k, first_ov, last_ld, n_stall;
    bit seen_done;
    op_e prev;
    seq.delete(); rc.delete(); outs.delete();
    load_cycles = 0; load_writes = 0; out_cycles = 0; done_cnt = 0;
    bank_ok = 1; finished = 0; first_ov = -1; last_ld = -1; n_stall = 0; seen_done = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("in_ready_after_start", bus.in_ready, 1);
    prev = OP_NOP;
    k = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.op != prev) begin
        seq.push_back(bus.op);
        k = 0;
        if (bus.op == OP_KEYX) rc.push_back(bus.rcon);
      end
      bus.in_valid = 0;
      bus.out_ready = 0;
      bus.start = 0;
      if (bus.op == OP_LOAD) begin
        load_cycles++;
        bus.in_valid = alt_in ? (k % 2 == 1) : 1'b1;
        if (bus.in_valid) last_ld = c;
      end
      if (bus.op == OP_OUT) begin
        out_cycles++;
        if (first_ov < 0) first_ov = c;
        if (bus.st_bank !== 1'b1) bank_ok = 0;
        bus.out_ready = !(stall_out && outs.size() == 6 && n_stall < 5);
        if (!bus.out_ready) begin
          n_stall++;
          chk("stall_hold_raddr", bus.st_raddr, 6);
        end else outs.push_back(bus.st_raddr);
      end
      if (bus.op == OP_SUB && bus.round == 1 && sub_exp(k) >= 0) begin
        chk("sub_waddr", bus.st_waddr, k);
        chk("sub_raddr", bus.st_raddr, sub_exp(k));
      end
      if (start_mid && bus.op == OP_SUB && bus.round == 4 && k == 0) bus.start = 1;
      if (rst_mid && bus.op == OP_MIX && bus.round == 2 && k == 7) begin
        rst = 1;
        tick();
        rst = 0;
        bus.out_ready = 0;
        bus.in_valid = 0;
        chk("rst_op", bus.op, OP_NOP);
        chk("rst_busy", bus.busy, 0);
        chk("rst_round", bus.round, 0);
        chk("rst_rcon", bus.rcon, 8'h01);
        chk("rst_bank", bus.st_bank, 0);
        chk("rst_done", bus.done, 0);
        finished = 1;
        return;
      end
      #1;
      if (bus.op == OP_LOAD && bus.st_we) load_writes++;
      if (bus.done) begin
        done_cnt++;
        seen_done = 1;
      end else if (seen_done && bus.op == OP_NOP) begin
        finished = 1;
        break;
      end
      prev = bus.op;
      k++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 0;
    lat = first_ov - last_ld;
    if (!finished) chk("block_timeout", 0, 1);
  endtask

  task automatic check_block(input string tag, input int exp_load, input int exp_out);
    int bad;
    chk({tag, "_seq_len"}, seq.size(), exp_seq.size());
    bad = 0;
    foreach (exp_seq[i]) if (i >= seq.size() || seq[i] != exp_seq[i]) bad++;
    chk({tag, "_seq_order"}, bad, 0);
    chk({tag, "_latency"}, lat, 641);
    chk({tag, "_load_cycles"}, load_cycles, exp_load);
    chk({tag, "_load_writes"}, load_writes, 16);
    chk({tag, "_out_cycles"}, out_cycles, exp_out);
    chk({tag, "_out_len"}, outs.size(), 16);
    bad = 0;
    foreach (outs[i]) if (outs[i] != 4'(i)) bad++;
    chk({tag, "_out_order"}, bad, 0);
    chk({tag, "_rcon_len"}, rc.size(), 10);
    bad = 0;
    foreach (exp_rc[i]) if (i >= rc.size() || rc[i] != exp_rc[i]) bad++;
    chk({tag, "_rcon_seq"}, bad, 0);
    chk({tag, "_out_bank"}, bank_ok, 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    exp_seq = '{OP_LOAD, OP_ARK};
    repeat (9) begin
      exp_seq.push_back(OP_KEYX); exp_seq.push_back(OP_SUB);
      exp_seq.push_back(OP_MIX); exp_seq.push_back(OP_ARK);
    end
    exp_seq.push_back(OP_KEYX); exp_seq.push_back(OP_SUB);
    exp_seq.push_back(OP_ARK); exp_seq.push_back(OP_OUT); exp_seq.push_back(OP_NOP);
    bus.start = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    repeat (3) tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_op", bus.op, OP_NOP);
    chk("reset_rcon", bus.rcon, 8'h01);
    chk("reset_round", bus.round, 0);
    chk("reset_bank", bus.st_bank, 0);
    chk("reset_we", bus.st_we, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_last_round", bus.last_round, 0);
    rst = 0;
    tick();
    run_block(0, 0, 0, 0);
    check_block("plain", 16, 16);
    tick();
    run_block(1, 1, 0, 0);
    check_block("stall", 32, 21);
    tick();
    run_block(0, 0, 1, 0);
    check_block("late_start", 16, 16);
    tick();
    run_block(0, 0, 0, 1);
    tick();
    run_block(0, 0, 0, 0);
    check_block("after_rst", 16, 16);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
